// File: rtl/request_unit.sv
// Memory request sequencer: serializes instruction fetch and data access, makes halt sticky,
// counts completed data transfers. Optional stall watchdog enabled by defining REQ_WATCHDOG_EN.
module request_unit #(
    parameter int CNT_W    = 32,
    parameter int WD_LIMIT = 1024
) (
    input  logic             CLK,
    input  logic             nRST,
    input  logic             ihit,
    input  logic             dhit,
    input  logic             dREN_req,
    input  logic             dWEN_req,
    input  logic             halt_in,
    output logic             iREN,
    output logic             dREN,
    output logic             dWEN,
    output logic             busy,
    output logic             halted,
    output logic [CNT_W-1:0] dxfer_cnt,
    output logic             wd_timeout
);

    // state | meaning
    // FETCH | instruction read outstanding, waiting for ihit
    // DATA  | latched load/store outstanding, waiting for dhit
    // HALT  | sticky stop, left only through reset
    typedef enum logic [1:0] {
        FETCH = 2'd0,
        DATA  = 2'd1,
        HALT  = 2'd2
    } state_t;

    localparam int WD_W = $clog2(WD_LIMIT + 1);

    state_t           state_q, state_d;
    logic             dren_q, dren_d;
    logic             dwen_q, dwen_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_q <= FETCH;
            dren_q  <= 1'b0;
            dwen_q  <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            dren_q  <= dren_d;
            dwen_q  <= dwen_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        dren_d  = dren_q;
        dwen_d  = dwen_q;
        cnt_d   = cnt_q;
        case (state_q)
            FETCH: begin
                if (ihit) begin
                    if (halt_in) begin
                        state_d = HALT;
                    end else if (dREN_req || dWEN_req) begin
                        state_d = DATA;
                        // a store wins when both requests are decoded
                        dwen_d  = dWEN_req;
                        dren_d  = dREN_req & ~dWEN_req;
                    end
                end
            end
            DATA: begin
                if (dhit) begin
                    state_d = FETCH;
                    dren_d  = 1'b0;
                    dwen_d  = 1'b0;
                    cnt_d   = cnt_q + CNT_W'(1);
                end
            end
            HALT: begin
            end
            default: begin
                state_d = FETCH;
                dren_d  = 1'b0;
                dwen_d  = 1'b0;
            end
        endcase
    end

    assign iREN      = (state_q == FETCH);
    assign busy      = (state_q == DATA);
    assign halted    = (state_q == HALT);
    assign dREN      = dren_q;
    assign dWEN      = dwen_q;
    assign dxfer_cnt = cnt_q;

`ifdef REQ_WATCHDOG_EN
    logic [WD_W-1:0] stall_q, stall_d;
    logic            wd_q, wd_d;
    logic            stall, leave;

    assign stall = ((state_q == FETCH) && !ihit) || ((state_q == DATA) && !dhit);
    assign leave = (state_d != state_q);

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            stall_q <= '0;
            wd_q    <= 1'b0;
        end else begin
            stall_q <= stall_d;
            wd_q    <= wd_d;
        end
    end

    // flag raised in the same cycle the counter lands on the limit
    always_comb begin
        stall_d = stall_q;
        wd_d    = wd_q;
        if (leave) begin
            stall_d = '0;
        end else if (stall && (stall_q != WD_W'(WD_LIMIT))) begin
            stall_d = stall_q + WD_W'(1);
        end
        if (stall_d == WD_W'(WD_LIMIT)) begin
            wd_d = 1'b1;
        end
    end

    assign wd_timeout = wd_q;
`else
    logic [WD_W-1:0] wd_limit_unused;
    assign wd_limit_unused = WD_W'(WD_LIMIT);
    assign wd_timeout      = 1'b0;
`endif

endmodule

// File: tb/tb_request_unit.sv
// Directed bench for request_unit: vector table for the main sequence, hand sequences for reset and watchdog.
module tb_request_unit;

    localparam int CNT_W = 32;
`ifdef REQ_WATCHDOG_EN
    localparam bit WD_ON = 1'b1;
`else
    localparam bit WD_ON = 1'b0;
`endif

    logic             CLK = 1'b0;
    logic             nRST = 1'b0;
    logic             ihit = 1'b0, dhit = 1'b0, dREN_req = 1'b0, dWEN_req = 1'b0, halt_in = 1'b0;
    logic             iREN, dREN, dWEN, busy, halted, wd_timeout;
    logic [CNT_W-1:0] dxfer_cnt;

    int checks = 0;
    int failures = 0;

    request_unit #(.CNT_W(CNT_W), .WD_LIMIT(8)) dut (
        .CLK(CLK), .nRST(nRST), .ihit(ihit), .dhit(dhit), .dREN_req(dREN_req),
        .dWEN_req(dWEN_req), .halt_in(halt_in), .iREN(iREN), .dREN(dREN), .dWEN(dWEN),
        .busy(busy), .halted(halted), .dxfer_cnt(dxfer_cnt), .wd_timeout(wd_timeout)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic ihit, dhit, drq, wrq, hlt;
        logic e_iren, e_dren, e_dwen, e_busy, e_halted;
        int   e_cnt;
    } vec_t;

    vec_t vecs[16];

    task automatic check(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_outs(input string tag, input logic ir, input logic dr, input logic dw,
                              input logic bz, input logic hl, input int cnt);
        check({tag, ".iREN"}, iREN, ir);
        check({tag, ".dREN"}, dREN, dr);
        check({tag, ".dWEN"}, dWEN, dw);
        check({tag, ".busy"}, busy, bz);
        check({tag, ".halted"}, halted, hl);
        check({tag, ".cnt"}, dxfer_cnt, cnt);
    endtask

    task automatic drive(input logic ih, input logic dh, input logic dr, input logic dw, input logic hl);
        ihit = ih; dhit = dh; dREN_req = dr; dWEN_req = dw; halt_in = hl;
    endtask

    task automatic step;
        @(posedge CLK);
        #1;
    endtask

    initial begin
        //              ih dh dr wr hl | ir dr dw bz hl cnt
        vecs[0]  = '{1, 0, 0, 0, 0,   1, 0, 0, 0, 0, 0};
        vecs[1]  = '{1, 0, 0, 0, 0,   1, 0, 0, 0, 0, 0};
        vecs[2]  = '{0, 0, 0, 0, 0,   1, 0, 0, 0, 0, 0};
        vecs[3]  = '{0, 1, 0, 0, 0,   1, 0, 0, 0, 0, 0};
        vecs[4]  = '{1, 0, 1, 0, 0,   0, 1, 0, 1, 0, 0};
        vecs[5]  = '{0, 0, 0, 0, 0,   0, 1, 0, 1, 0, 0};
        vecs[6]  = '{1, 0, 0, 1, 1,   0, 1, 0, 1, 0, 0};
        vecs[7]  = '{0, 1, 0, 0, 0,   1, 0, 0, 0, 0, 1};
        vecs[8]  = '{1, 0, 1, 1, 0,   0, 0, 1, 1, 0, 1};
        vecs[9]  = '{1, 1, 0, 0, 0,   1, 0, 0, 0, 0, 2};
        vecs[10] = '{0, 0, 0, 1, 0,   1, 0, 0, 0, 0, 2};
        vecs[11] = '{1, 0, 0, 1, 0,   0, 0, 1, 1, 0, 2};
        vecs[12] = '{1, 1, 0, 0, 0,   1, 0, 0, 0, 0, 3};
        vecs[13] = '{1, 0, 0, 1, 1,   0, 0, 0, 0, 1, 3};
        vecs[14] = '{1, 1, 1, 0, 0,   0, 0, 0, 0, 1, 3};
        vecs[15] = '{0, 0, 0, 0, 0,   0, 0, 0, 0, 1, 3};

        drive(0, 0, 0, 0, 0);
        #12;
        check_outs("reset", 1, 0, 0, 0, 0, 0);
        check("reset.wd", wd_timeout, 0);
        nRST = 1'b1;
        #2;

        for (int i = 0; i < 16; i++) begin
            drive(vecs[i].ihit, vecs[i].dhit, vecs[i].drq, vecs[i].wrq, vecs[i].hlt);
            step();
            check_outs($sformatf("vec%0d", i), vecs[i].e_iren, vecs[i].e_dren, vecs[i].e_dwen,
                       vecs[i].e_busy, vecs[i].e_halted, vecs[i].e_cnt);
        end

        // reset pulse leaves HALT
        drive(0, 0, 0, 0, 0);
        #3; nRST = 1'b0; #2;
        check_outs("halt_rst", 1, 0, 0, 0, 0, 0);
        nRST = 1'b1;
        step();

        // one completed load, then a store aborted by reset mid-DATA
        drive(1, 0, 1, 0, 0); step();
        drive(0, 1, 0, 0, 0); step();
        check_outs("ld_done", 1, 0, 0, 0, 0, 1);
        drive(1, 0, 0, 1, 0); step();
        check_outs("st_data", 0, 0, 1, 1, 0, 1);
        drive(0, 0, 0, 0, 0);
        #3; nRST = 1'b0; #1;
        check_outs("st_abort", 1, 0, 0, 0, 0, 0);
        #2; nRST = 1'b1;
        step();
        check_outs("post_abort", 1, 0, 0, 0, 0, 0);

        // watchdog: 8 DATA cycles without dhit
        drive(1, 0, 1, 0, 0); step();
        drive(0, 0, 0, 0, 0);
        for (int c = 1; c <= 8; c++) begin
            step();
            if (c == 7) check("wd_c7", wd_timeout, 0);
        end
        check("wd_c8", wd_timeout, WD_ON);
        check("wd_busy", busy, 1);
        drive(0, 1, 0, 0, 0); step();
        check("wd_sticky", wd_timeout, WD_ON);
        check_outs("wd_done", 1, 0, 0, 0, 0, 1);
        drive(1, 0, 0, 0, 0); step();
        check("wd_sticky2", wd_timeout, WD_ON);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
